// File: rtl/reg_file_mp.sv
// Parametrised multi-port register file with per-port valid/ready handshakes.
// Each read port and the single write port runs an independent IDLE/BUSY FSM.
// The memory is read or written on the completion edge, which comes LATENCY
// edges after the request is accepted.
//
// state | meaning
// IDLE  | port has no operation in flight; ready is high
// BUSY  | operation accepted; down-counter runs to zero, then it completes
module reg_file_mp #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 5,
    parameter int DEPTH    = 32,
    parameter int NRD      = 2,
    parameter int LATENCY  = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NRD-1:0]               rd_valid,
    output logic [NRD-1:0]               rd_ready,
    input  logic [NRD*ADDR_W-1:0]        rd_addr,
    output logic signed [NRD*DATA_W-1:0] rd_data,
    output logic [NRD-1:0]               rd_done,
    input  logic                         wr_valid,
    output logic                         wr_ready,
    input  logic [ADDR_W-1:0]            wr_addr,
    input  logic [DATA_W-1:0]            wr_data,
    output logic                         wr_done,
    output logic                         any_done
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(LATENCY - 1);
    localparam logic [ADDR_W:0]   DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

    // Addresses past the end of the array behave as read-zero / write-discard.
    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return {1'b0, a} < DEPTH_LIM;
    endfunction

    // Entry 0 is pinned to zero when ZERO_REG is set.
    function automatic logic is_pinned(input logic [ADDR_W-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            wr_state;
    logic [CNT_W-1:0]  wr_cnt;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [DATA_W-1:0] wr_data_q;
    logic              wr_commit;
    logic              wr_keep;

    assign wr_ready  = (wr_state == IDLE) || (wr_cnt == '0);
    assign wr_commit = (wr_state == BUSY) && (wr_cnt == '0);
    assign wr_keep   = in_range(wr_addr_q) && !is_pinned(wr_addr_q);

    // Write port FSM: capture on accept, count down, commit on terminal count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_state  <= IDLE;
            wr_cnt    <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            wr_done   <= 1'b0;
        end else begin
            wr_done <= wr_commit;
            if (wr_valid && wr_ready) begin
                wr_state  <= BUSY;
                wr_cnt    <= CNT_LOAD;
                wr_addr_q <= wr_addr;
                wr_data_q <= wr_data;
            end else if (wr_state == BUSY) begin
                if (wr_cnt == '0) begin
                    wr_state <= IDLE;
                end else begin
                    wr_cnt <= wr_cnt - CNT_W'(1);
                end
            end
        end
    end

    // Storage array: cleared by reset, updated on the write completion edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < DEPTH; j++) begin
                mem[j] <= '0;
            end
        end else if (wr_commit && wr_keep) begin
            mem[wr_addr_q] <= wr_data_q;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NRD; gi++) begin : g_rd
            state_t            state;
            logic [CNT_W-1:0]  cnt;
            logic [ADDR_W-1:0] addr_q;
            logic [DATA_W-1:0] data_q;
            logic              done_q;
            logic              fire;
            logic [DATA_W-1:0] rd_val;

            assign rd_ready[gi] = (state == IDLE) || (cnt == '0);
            assign fire         = (state == BUSY) && (cnt == '0);
            assign rd_done[gi]  = done_q;
            assign rd_data[gi*DATA_W +: DATA_W] = data_q;

            // Value seen at completion; the same-edge write is forwarded only with BYPASS.
            always_comb begin
                rd_val = '0;
                if (in_range(addr_q) && !is_pinned(addr_q)) begin
                    if ((BYPASS != 0) && wr_commit && wr_keep && (wr_addr_q == addr_q)) begin
                        rd_val = wr_data_q;
                    end else begin
                        rd_val = mem[addr_q];
                    end
                end
            end

            // Read port FSM: capture address on accept, load result on terminal count.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    state  <= IDLE;
                    cnt    <= '0;
                    addr_q <= '0;
                    data_q <= '0;
                    done_q <= 1'b0;
                end else begin
                    done_q <= fire;
                    if (fire) begin
                        data_q <= rd_val;
                    end
                    if (rd_valid[gi] && rd_ready[gi]) begin
                        state  <= BUSY;
                        cnt    <= CNT_LOAD;
                        addr_q <= rd_addr[gi*ADDR_W +: ADDR_W];
                    end else if (state == BUSY) begin
                        if (cnt == '0) begin
                            state <= IDLE;
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
                end
            end
        end
    endgenerate

    assign any_done = (|rd_done) | wr_done;

endmodule
